// File: rtl/exception_ctrl.sv
// Exception/interrupt sequencer for the single-issue LEGv8 core: owns ELR/ESR/EMode,
// redirects fetch on entry and return, drains younger stages and acknowledges IRQs.
module exception_ctrl #(
  parameter int             N            = 64,
  parameter logic [N-1:0]   VECTOR       = 'hD8,
  parameter int             FLUSH_CYCLES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [N-1:0] pc_d,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExtIRQ,
  output logic         ExtIAck,
  output logic         redirect,
  output logic [N-1:0] redirect_pc,
  output logic         flush,
  output logic [N-1:0] ELR,
  output logic [3:0]   ESR,
  output logic         EMode,
  output logic         halted
);

  localparam int            CW       = $clog2(FLUSH_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FLUSH_CYCLES - 1);

  localparam logic [3:0] ESR_NONE  = 4'b0000;
  localparam logic [3:0] ESR_IRQ   = 4'b0001;
  localparam logic [3:0] ESR_UNDEF = 4'b0010;
  localparam logic [3:0] ESR_DFLT  = 4'b0011;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    FLUSH_IN  = 3'd1,
    HANDLER   = 3'd2,
    FLUSH_OUT = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic           r_ack;
  logic           r_redirect;
  logic [N-1:0]   r_redirect_pc;
  logic           r_flush;
  logic [N-1:0]   r_elr;
  logic [3:0]     r_esr;
  logic           r_emode;
  logic           r_halted;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_ack         <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_flush       <= 1'b0;
      r_elr         <= '0;
      r_esr         <= ESR_NONE;
      r_emode       <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle, so any set below lasts exactly one cycle.
      r_ack         <= 1'b0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;

      case (r_state)
        RUN: begin
          // A synchronous fault outranks the IRQ; the IRQ stays pending (no ack).
          if (valid && (NotAnInstr || ERet)) begin
            r_elr         <= pc_d;
            r_esr         <= ESR_UNDEF;
            r_redirect    <= 1'b1;
            r_redirect_pc <= VECTOR;
            r_flush       <= 1'b1;
            r_cnt         <= '0;
            r_state       <= FLUSH_IN;
          end else if (valid && ExtIRQ) begin
            r_elr         <= pc_d;
            r_esr         <= ESR_IRQ;
            r_ack         <= 1'b1;
            r_redirect    <= 1'b1;
            r_redirect_pc <= VECTOR;
            r_flush       <= 1'b1;
            r_cnt         <= '0;
            r_state       <= FLUSH_IN;
          end
        end

        FLUSH_IN: begin
          if (r_cnt == CNT_LAST) begin
            r_flush <= 1'b0;
            r_emode <= 1'b1;
            r_cnt   <= '0;
            r_state <= HANDLER;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        HANDLER: begin
          if (valid && ERet) begin
            r_redirect    <= 1'b1;
            r_redirect_pc <= r_elr;
            r_flush       <= 1'b1;
            r_cnt         <= '0;
            r_state       <= FLUSH_OUT;
          end else if (valid && NotAnInstr) begin
            r_esr    <= ESR_DFLT;
            r_flush  <= 1'b1;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end
        end

        FLUSH_OUT: begin
          if (r_cnt == CNT_LAST) begin
            r_flush <= 1'b0;
            r_emode <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        HALT: begin
          r_flush  <= 1'b1;
          r_halted <= 1'b1;
        end

        default: r_state <= RUN;
      endcase
    end
  end

  assign ExtIAck     = r_ack;
  assign redirect    = r_redirect;
  assign redirect_pc = r_redirect_pc;
  assign flush       = r_flush;
  assign ELR         = r_elr;
  assign ESR         = r_esr;
  assign EMode       = r_emode;
  assign halted      = r_halted;

endmodule

// File: tb/tb_exception_ctrl.sv
// Table-driven bench for exception_ctrl: each record is the input applied at one rising
// edge and the registered outputs expected just after it, compared through a scoreboard queue.
module tb_exception_ctrl;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid;
  logic [N-1:0] pc_d;
  logic         NotAnInstr;
  logic         ERet;
  logic         ExtIRQ;
  logic         ExtIAck;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         flush;
  logic [N-1:0] ELR;
  logic [3:0]   ESR;
  logic         EMode;
  logic         halted;

  exception_ctrl #(.N(N), .VECTOR('hD8), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .valid(valid), .pc_d(pc_d),
    .NotAnInstr(NotAnInstr), .ERet(ERet), .ExtIRQ(ExtIRQ),
    .ExtIAck(ExtIAck), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .ELR(ELR), .ESR(ESR), .EMode(EMode), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst, vld, nai, eret, irq;
    logic [N-1:0] pc;
    logic         ack, rd, fl, em, hl;
    logic [N-1:0] rpc, elr;
    logic [3:0]   esr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic rst, vld, input logic [N-1:0] pc, input logic nai, eret, irq,
                     input logic ack, rd, input logic [N-1:0] rpc, input logic fl,
                     input logic [N-1:0] elr, input logic [3:0] esr, input logic em, hl);
    vec_t v;
    v.rst = rst; v.vld = vld; v.pc = pc; v.nai = nai; v.eret = eret; v.irq = irq;
    v.ack = ack; v.rd = rd; v.rpc = rpc; v.fl = fl; v.elr = elr; v.esr = esr;
    v.em = em; v.hl = hl;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one record, push its expectation, then compare just after the sampling edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    @(negedge clk);
    reset = v.rst; valid = v.vld; pc_d = v.pc;
    NotAnInstr = v.nai; ERet = v.eret; ExtIRQ = v.irq;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d.ExtIAck", idx),     N'(ExtIAck),  N'(e.ack));
    check($sformatf("v%0d.redirect", idx),    N'(redirect), N'(e.rd));
    check($sformatf("v%0d.redirect_pc", idx), redirect_pc,  e.rpc);
    check($sformatf("v%0d.flush", idx),       N'(flush),    N'(e.fl));
    check($sformatf("v%0d.ELR", idx),         ELR,          e.elr);
    check($sformatf("v%0d.ESR", idx),         N'(ESR),      N'(e.esr));
    check($sformatf("v%0d.EMode", idx),       N'(EMode),    N'(e.em));
    check($sformatf("v%0d.halted", idx),      N'(halted),   N'(e.hl));
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; pc_d = '0; NotAnInstr = 1'b0; ERet = 1'b0; ExtIRQ = 1'b0;

    //   rst vld pc    nai er irq | ack rd rpc  fl elr   esr em hl
    add(1, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h0,   0, 0, 0); // reset state
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h0,   0, 0, 0);
    add(0, 1, 'h40,  1, 0, 0,   0, 1, 'hD8, 1, 'h40,  2, 0, 0); // invalid opcode entry
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h40,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h40,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h40,  2, 1, 0); // HANDLER
    add(0, 1, 'h44,  0, 0, 1,   0, 0, 'h0,  0, 'h40,  2, 1, 0); // IRQ masked
    add(0, 1, 'h50,  0, 1, 0,   0, 1, 'h40, 1, 'h40,  2, 1, 0); // ERET
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h40,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h40,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h40,  2, 0, 0); // RUN, ESR kept
    add(0, 1, 'h100, 0, 0, 1,   1, 1, 'hD8, 1, 'h100, 1, 0, 0); // IRQ entry
    add(0, 1, 'h104, 1, 0, 0,   0, 0, 'h0,  1, 'h100, 1, 0, 0); // ignored in FLUSH_IN
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h100, 1, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h100, 1, 1, 0);
    add(0, 1, 'h200, 0, 0, 0,   0, 0, 'h0,  0, 'h100, 1, 1, 0);
    add(0, 1, 'h0,   0, 1, 0,   0, 1, 'h100,1, 'h100, 1, 1, 0); // return to 0x100
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h100, 1, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h100, 1, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h100, 1, 0, 0);
    add(0, 1, 'h300, 0, 0, 0,   0, 0, 'h0,  0, 'h100, 1, 0, 0); // no second entry
    add(0, 0, 'h304, 1, 0, 0,   0, 0, 'h0,  0, 'h100, 1, 0, 0); // bubble ignored
    add(0, 0, 'h308, 0, 0, 1,   0, 0, 'h0,  0, 'h100, 1, 0, 0); // IRQ needs valid
    add(0, 1, 'h80,  1, 0, 1,   0, 1, 'hD8, 1, 'h80,  2, 0, 0); // fault beats IRQ
    add(0, 1, 'h84,  0, 0, 1,   0, 0, 'h0,  1, 'h80,  2, 0, 0);
    add(0, 1, 'h84,  0, 0, 1,   0, 0, 'h0,  1, 'h80,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 1,   0, 0, 'h0,  0, 'h80,  2, 1, 0);
    add(0, 1, 'h88,  0, 0, 1,   0, 0, 'h0,  0, 'h80,  2, 1, 0);
    add(0, 1, 'h90,  0, 1, 1,   0, 1, 'h80, 1, 'h80,  2, 1, 0); // ERET, IRQ pending
    add(0, 0, 'h0,   0, 0, 1,   0, 0, 'h0,  1, 'h80,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 1,   0, 0, 'h0,  1, 'h80,  2, 1, 0);
    add(0, 1, 'h86,  0, 0, 1,   0, 0, 'h0,  0, 'h80,  2, 0, 0);
    add(0, 1, 'h84,  0, 0, 1,   1, 1, 'hD8, 1, 'h84,  1, 0, 0); // first RUN cycle: IRQ taken
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h84,  1, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h84,  1, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h84,  1, 1, 0);
    add(0, 1, 'h88,  1, 0, 0,   0, 0, 'h0,  1, 'h84,  3, 1, 1); // double fault
    add(0, 1, 'h8C,  0, 1, 0,   0, 0, 'h0,  1, 'h84,  3, 1, 1);
    add(0, 1, 'h90,  0, 0, 1,   0, 0, 'h0,  1, 'h84,  3, 1, 1);

    foreach (vecs[i]) step(vecs[i], i);

    // Halt is sticky across idle cycles until reset.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      reset = 1'b0; valid = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; ExtIRQ = 1'b0;
      @(posedge clk);
      #1;
      check($sformatf("halt_hold%0d.halted", k), N'(halted), N'(1'b1));
      check($sformatf("halt_hold%0d.flush", k),  N'(flush),  N'(1'b1));
    end

    // Reset mid-flush, then normal handling of a fresh fault and an illegal ERET in RUN.
    vecs.delete();
    add(1, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h0,   0, 0, 0);
    add(0, 1, 'h40,  1, 0, 0,   0, 1, 'hD8, 1, 'h40,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h40,  2, 0, 0);
    add(1, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h0,   0, 0, 0); // reset in 2nd FLUSH_IN cycle
    add(0, 1, 'h60,  1, 0, 0,   0, 1, 'hD8, 1, 'h60,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h60,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h60,  2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h60,  2, 1, 0);
    add(0, 1, 'h0,   0, 1, 0,   0, 1, 'h60, 1, 'h60,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h60,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h60,  2, 1, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h60,  2, 0, 0);
    add(0, 1, 'h300, 0, 1, 0,   0, 1, 'hD8, 1, 'h300, 2, 0, 0); // ERET outside handler
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h300, 2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  1, 'h300, 2, 0, 0);
    add(0, 0, 'h0,   0, 0, 0,   0, 0, 'h0,  0, 'h300, 2, 1, 0);

    foreach (vecs[i]) step(vecs[i], 100 + i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
